// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte over a valid/ready handshake and
// serialises it LSB first on TXD with one start bit and one stop bit.
`timescale 1ns/1ps
module uart_tx #(
  parameter logic [31:0] FREQ_CLK = 32'd100000000,
  parameter logic [31:0] TX_SPEED = 32'd115200
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] TX_Data,
  input  logic       TX_Valid,
  output logic       TX_Ready,
  output logic       TXD,
  output logic       TX_Busy,
  output logic       TX_Done
);

  localparam logic [31:0] BIT_CYCLES = FREQ_CLK / TX_SPEED;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        bitEnd;

  assign bitEnd   = (cnt_q == BIT_CYCLES - 32'd1);
  assign TX_Ready = (state_q == IDLE);
  assign TX_Busy  = (state_q != IDLE);
  assign TX_Done  = (state_q == STOP) && bitEnd;
  assign TXD      = txd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    txd_d    = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (TX_Valid) begin
          state_d  = START;
          shift_d  = TX_Data;
          bitIdx_d = 3'd0;
        end
      end
      START: begin
        if (bitEnd) begin
          cnt_d    = 32'd0;
          state_d  = DATA;
          bitIdx_d = 3'd0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          cnt_d   = 32'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          cnt_d   = 32'd0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
    endcase

    // TXD is registered, so it is derived from the upcoming state to stay aligned with it.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      bitIdx_q <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a per-cycle waveform model built from 8N1
// framing rules, a bench UART receiver, and directed run-length checks.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int BC = 10;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       TX_Valid = 1'b0;
  logic [7:0] TX_Data = 8'h00;
  logic       TX_Ready;
  logic       TXD;
  logic       TX_Busy;
  logic       TX_Done;

  int testsRun = 0;
  int testsFailed = 0;

  uart_tx #(
    .FREQ_CLK(32'd100),
    .TX_SPEED(32'd10)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .TX_Data (TX_Data),
    .TX_Valid(TX_Valid),
    .TX_Ready(TX_Ready),
    .TXD     (TXD),
    .TX_Busy (TX_Busy),
    .TX_Done (TX_Done)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic frameBit(input logic [7:0] data, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return data[b-1];
  endfunction

  // Model: each accepted byte becomes 10 bits of BC cycles each; empty queue means idle.
  logic expTxdQ[$];
  logic expDoneQ[$];
  logic expTxd = 1'b1;
  logic expDone = 1'b0;
  logic expReady = 1'b1;
  bit   modelOn = 1'b0;

  always @(posedge Clk) begin
    if (!Rst_n) begin
      expTxdQ.delete();
      expDoneQ.delete();
      modelOn = 1'b1;
    end else if (expReady && TX_Valid) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < BC; c++) begin
          expTxdQ.push_back(frameBit(TX_Data, b));
          expDoneQ.push_back((b == 9) && (c == BC - 1));
        end
      end
    end
    if (expTxdQ.size() > 0) begin
      expTxd   = expTxdQ.pop_front();
      expDone  = expDoneQ.pop_front();
      expReady = 1'b0;
    end else begin
      expTxd   = 1'b1;
      expDone  = 1'b0;
      expReady = 1'b1;
    end
  end

  always @(negedge Clk) begin
    if (modelOn) begin
      checkOutput("TXD", {31'd0, TXD}, {31'd0, expTxd});
      checkOutput("TX_Ready", {31'd0, TX_Ready}, {31'd0, expReady});
      checkOutput("TX_Busy", {31'd0, TX_Busy}, {31'd0, ~expReady});
      checkOutput("TX_Done", {31'd0, TX_Done}, {31'd0, expDone});
    end
  end

  // Run-length monitor on TXD and TX_Done pulse counter.
  int   lowRuns[$];
  int   highRuns[$];
  logic runLevel = 1'b1;
  int   runLen = 0;
  int   doneCount = 0;

  always @(negedge Clk) begin
    if (TX_Done === 1'b1) doneCount++;
    if (TXD === runLevel) begin
      runLen++;
    end else begin
      if (runLevel) highRuns.push_back(runLen);
      else lowRuns.push_back(runLen);
      runLevel = TXD;
      runLen = 1;
    end
  end

  // Bench receiver: samples mid-bit, abandons a frame if reset is seen.
  logic [7:0] rxQ[$];
  logic       rxPrev = 1'b1;
  logic [7:0] rxByte;
  bit         rxAbort;

  always begin
    @(negedge Clk);
    if (Rst_n && rxPrev === 1'b1 && TXD === 1'b0) begin
      rxAbort = 1'b0;
      rxByte = 8'h00;
      for (int k = 1; k <= 95; k++) begin
        @(negedge Clk);
        if (!Rst_n) begin
          rxAbort = 1'b1;
          break;
        end
        if (k == 5) checkOutput("rx start bit", {31'd0, TXD}, 32'd0);
        if (k >= 15 && k <= 85 && (k - 5) % 10 == 0) rxByte[(k-15)/10] = TXD;
        if (k == 95) checkOutput("rx stop bit", {31'd0, TXD}, 32'd1);
      end
      if (!rxAbort) rxQ.push_back(rxByte);
    end
    rxPrev = TXD;
  end

  task automatic waitReady();
    int n = 0;
    while (TX_Ready !== 1'b1 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (TX_Ready !== 1'b1) checkOutput("waitReady timeout", {31'd0, TX_Ready}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    waitReady();
    TX_Data  = data;
    TX_Valid = 1'b1;
    @(negedge Clk);
    TX_Valid = 1'b0;
  endtask

  task automatic clearRuns();
    #1;
    lowRuns.delete();
    highRuns.delete();
  endtask

  logic [7:0] expBytes[7] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h96, 8'h5A};
  int cyc;

  initial begin
    // Reset with a pending request: nothing may leave the transmitter.
    Rst_n    = 1'b0;
    TX_Valid = 1'b1;
    TX_Data  = 8'h11;
    repeat (5) @(negedge Clk);
    checkOutput("reset TXD", {31'd0, TXD}, 32'd1);
    checkOutput("reset TX_Ready", {31'd0, TX_Ready}, 32'd1);
    checkOutput("reset TX_Busy", {31'd0, TX_Busy}, 32'd0);
    checkOutput("reset TX_Done", {31'd0, TX_Done}, 32'd0);
    Rst_n    = 1'b1;
    TX_Valid = 1'b0;
    repeat (3) @(negedge Clk);

    // 0xA5 frame with done latency
    clearRuns();
    @(negedge Clk);
    applyStimulus(8'hA5);
    cyc = 1;
    while (TX_Done !== 1'b1 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    checkOutput("A5 done cycle", cyc, 32'd100);
    waitReady();
    #1;
    checkOutput("A5 low run count", lowRuns.size(), 32'd4);
    checkOutput("A5 low run 0", lowRuns[0], 32'd10);
    checkOutput("A5 low run 1", lowRuns[1], 32'd10);
    checkOutput("A5 low run 2", lowRuns[2], 32'd20);
    checkOutput("A5 low run 3", lowRuns[3], 32'd10);
    @(negedge Clk);

    // All-zero and all-one bytes
    clearRuns();
    @(negedge Clk);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    waitReady();
    #1;
    checkOutput("00/FF low run count", lowRuns.size(), 32'd2);
    checkOutput("00 low run", lowRuns[0], 32'd90);
    checkOutput("FF low run", lowRuns[1], 32'd10);
    repeat (5) @(negedge Clk);

    // Back-to-back with TX_Valid held high
    clearRuns();
    @(negedge Clk);
    waitReady();
    TX_Data  = 8'h3C;
    TX_Valid = 1'b1;
    @(negedge Clk);
    TX_Data  = 8'hC3;
    waitReady();
    @(negedge Clk);
    TX_Valid = 1'b0;
    waitReady();
    #1;
    checkOutput("b2b low run count", lowRuns.size(), 32'd4);
    checkOutput("b2b low run 0", lowRuns[0], 32'd30);
    checkOutput("b2b low run 1", lowRuns[1], 32'd20);
    checkOutput("b2b low run 2", lowRuns[2], 32'd10);
    checkOutput("b2b low run 3", lowRuns[3], 32'd40);
    checkOutput("b2b high run 1", highRuns[1], 32'd40);
    checkOutput("b2b gap high run", highRuns[2], 32'd11);
    checkOutput("b2b high run 3", highRuns[3], 32'd20);
    repeat (5) @(negedge Clk);

    // Mid-frame request and data change are ignored
    applyStimulus(8'h96);
    repeat (40) @(negedge Clk);
    TX_Data  = 8'hFF;
    TX_Valid = 1'b1;
    @(negedge Clk);
    TX_Valid = 1'b0;
    TX_Data  = 8'h0F;
    waitReady();
    repeat (20) @(negedge Clk);

    // Reset during data bit 3, then a clean frame
    applyStimulus(8'h33);
    repeat (43) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    checkOutput("abort TXD", {31'd0, TXD}, 32'd1);
    checkOutput("abort TX_Busy", {31'd0, TX_Busy}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    applyStimulus(8'h5A);
    waitReady();
    repeat (15) @(negedge Clk);

    checkOutput("rx byte count", rxQ.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("rx byte %0d", i), {24'd0, rxQ[i]}, {24'd0, expBytes[i]});
    end
    checkOutput("done pulse count", doneCount, 32'd7);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
Sits on the controller's serial output path and pairs with the UART receiver, using the same FREQ_CLK/TX_SPEED bit timing.
A parallel byte is accepted through a valid/ready handshake and serialised on TXD.
Provides busy status and an end-of-frame pulse for the controller FSM.

Parameters:
FREQ_CLK, 100000000, system clock frequency in Hz (32-bit logic)
TX_SPEED, 115200, baud rate in bit/s (32-bit logic)
BIT_CYCLES (localparam), FREQ_CLK/TX_SPEED (integer division), Clk cycles per serial bit; must be >= 2

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  synchronous active-low reset
TX_Data  input  8  byte to transmit; sampled only on accept
TX_Valid  input  1  TX_Data valid request
TX_Ready  output  1  block can accept a byte this cycle
TXD  output  1  serial line, idle high
TX_Busy  output  1  frame in progress
TX_Done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Interface: reset Rst_n, synchronous, active-low; clock Clk.
- Reset (Rst_n=0 at a Clk edge) forces:
  - state=IDLE, TXD=1, TX_Busy=0, TX_Done=0.
  - All counters and the shift register cleared.
  - Applies mid-frame: the frame aborts immediately and TXD returns high on the next edge. No partial-frame recovery.
- TX_Ready = (state==IDLE), combinational. Accept = TX_Valid && TX_Ready at a rising edge. TX_Valid while not ready is ignored; no queueing.
- On accept:
  - TX_Data latched into an 8-bit shift register.
  - State moves to START; TXD driven 0 from the next cycle (TXD is registered, latency 1 cycle).
- Baud counter: 32-bit, counts 0..BIT_CYCLES-1. bit_end = (cnt==BIT_CYCLES-1). Each serial bit lasts exactly BIT_CYCLES cycles.
- States:
  - IDLE: TXD=1, counter held at 0. Go to START on accept.
  - START: TXD=0. On bit_end go to DATA with bit index 0.
  - DATA: TXD=shift[0]. On bit_end, shift right by 1. Bit index 0..7; on bit_end with index 7, go to STOP, else increment the index.
  - STOP: TXD=1. On bit_end, assert TX_Done for that cycle and go to IDLE.
  - Illegal or unused encodings go to IDLE with TXD=1.
- TX_Busy = (state!=IDLE), registered with the state.
- Frame length on TXD: 10*BIT_CYCLES cycles from the first low cycle to the end of the stop bit.
- Back-to-back: TX_Ready rises the cycle after TX_Done. Minimum gap between stop-bit end and the next start bit is 1 idle cycle (TXD=1), so the minimum frame slot is 10*BIT_CYCLES+1 cycles.
- TX_Data changes after accept do not affect the frame in flight.
- Data bit order on the wire: TX_Data[0] first, TX_Data[7] last.

Test Plan:
1. Reset with TX_Valid=1 held → TXD=1, TX_Busy=0, TX_Ready=1, TX_Done=0; no start bit emitted while Rst_n=0.
2. FREQ_CLK=100, TX_SPEED=10 (BIT_CYCLES=10), send 0xA5 → TXD low 10 cycles starting 1 cycle after accept. Then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. TX_Done pulses once at cycle 100 of the frame. A bench UART receiver decodes 0xA5.
3. Send 0x00, then 0xFF → TXD low for 90 cycles (start+8 data), then high. For 0xFF, low for exactly 10 cycles only. Bit widths exact to ±0 cycles.
4. Hold TX_Valid=1 with 0x3C then 0xC3 → two frames separated by exactly 1 idle-high cycle. TX_Ready=0 for the whole first frame; the second byte is accepted the cycle after TX_Done.
5. Change TX_Data and pulse TX_Valid mid-frame → ignored; the in-flight byte is unchanged and no extra frame is sent.
6. Assert Rst_n=0 during data bit 3 → TXD=1 and TX_Busy=0 on the next edge. After release, a new byte (0x5A) transmits correctly from its start bit.
